dm_responder: RTL and testbench

- Data-memory responder for the P6 pipelined MIPS core: answers load/store requests from the MEM stage over a req/ack handshake.
- Adds a configurable number of wait states so the pipeline's stall logic can be exercised.
- Backs a word-organised array covering data space 0x0000_0000 to 0x0000_2FFF.
- Flags out-of-range and misaligned accesses rather than corrupting memory.

---
 rtl/dm_responder_if.sv | 32 +++
 rtl/dm_responder.sv | 152 +++++++++++++++
 tb/tb_dm_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave).
//   req   : request valid, held by the master until ack is seen
//   we    : 1 = store, 0 = load
//   addr  : byte address
//   be    : store byte enables, bit i = byte lane i
//   wdata : lane-aligned store data
//   ack   : one-cycle completion pulse
//   rdata : load data, valid with ack and held until the next completion
//   err   : valid with ack, 1 = access rejected
//   busy  : high from acceptance until the end of the ack cycle
interface dm_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        err;
   logic        busy;

   modport master (
      output req, we, addr, be, wdata,
      input  ack, rdata, err, busy
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output ack, rdata, err, busy
   );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder for the pipelined MIPS core. Accepts one load/store at a
// time over a req/ack handshake, inserts WAIT wait states, and backs a DEPTH-word
// array. Out-of-range and misaligned accesses complete with err=1 and leave the
// array untouched.
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous active-low reset; clears the FSM, outputs and the array
//   bus   : dm_responder_if slave modport (req/we/addr/be/wdata in,
//           ack/rdata/err/busy out)
module dm_responder #(
   parameter int unsigned DEPTH = 3072,
   parameter int unsigned WAIT  = 2,
   parameter int unsigned CW    = 4
) (
   input logic           clk,
   input logic           reset,
   dm_responder_if.slave bus
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          enter_resp;

   logic          we_q;
   logic [31:0]   addr_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic [31:0]   mem_q [DEPTH];

   // Access resolved at the RESP-entry edge. With WAIT=0 that edge is the
   // acceptance edge itself, so the live bus values are used instead of the latch.
   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [3:0]    acc_be;
   logic [31:0]   acc_wdata;
   logic          acc_bad;
   logic [AW-1:0] acc_idx;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               if (WAIT == 0) begin
                  state_d    = StResp;
                  enter_resp = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = CW'(WAIT - 1);
               end
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d    = StResp;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.ack   = (state_q == StResp);
      bus.busy  = (state_q != StIdle);
      bus.rdata = rdata_q;
      bus.err   = err_q;
   end

   always_comb begin
      if (state_q == StIdle) begin
         acc_we    = bus.we;
         acc_addr  = bus.addr;
         acc_be    = bus.be;
         acc_wdata = bus.wdata;
      end else begin
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_be    = be_q;
         acc_wdata = wdata_q;
      end
      acc_bad = (acc_addr[31:2] >= 30'(DEPTH)) || (acc_addr[1:0] != 2'b00);
      acc_idx = acc_addr[AW+1:2];
   end

   // Request latch and response registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if ((state_q == StIdle) && bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            be_q    <= bus.be;
            wdata_q <= bus.wdata;
         end
         if (enter_resp) begin
            err_q <= acc_bad;
            if (acc_bad) begin
               rdata_q <= '0;
            end else if (!acc_we) begin
               rdata_q <= mem_q[acc_idx];
            end
         end
      end
   end

   // Storage array; stores commit lane by lane on RESP entry only
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[AW'(i)] <= '0;
         end
      end else if (enter_resp && acc_we && !acc_bad) begin
         for (int l = 0; l < 4; l++) begin
            if (acc_be[l]) begin
               mem_q[acc_idx][8*l +: 8] <= acc_wdata[8*l +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder. Two instances: WAIT=2 (main) and WAIT=0.
// Expected responses are pushed to a scoreboard when a request is driven and
// popped by a monitor whenever the selected instance pulses ack.
module tb_dm_responder;

   localparam int unsigned DEPTH  = 3072;
   localparam int unsigned WAIT_A = 2;
   localparam int unsigned WAIT_B = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      bit          chk_rdata;
   } exp_t;

   logic        clk;
   logic        reset;
   bit          sel;
   logic        req_s;
   logic        we_s;
   logic [31:0] addr_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s;

   logic        m_ack;
   logic        m_busy;
   logic        m_err;
   logic [31:0] m_rdata;

   exp_t        sb [$];
   exp_t        mon_e;
   logic [31:0] model [bit [32:0]];
   int          n_checks = 0;
   int          n_errors = 0;

   dm_responder_if bus_a ();
   dm_responder_if bus_b ();

   assign bus_a.req   = req_s & ~sel;
   assign bus_a.we    = we_s;
   assign bus_a.addr  = addr_s;
   assign bus_a.be    = be_s;
   assign bus_a.wdata = wdata_s;
   assign bus_b.req   = req_s & sel;
   assign bus_b.we    = we_s;
   assign bus_b.addr  = addr_s;
   assign bus_b.be    = be_s;
   assign bus_b.wdata = wdata_s;

   assign m_ack   = sel ? bus_b.ack   : bus_a.ack;
   assign m_busy  = sel ? bus_b.busy  : bus_a.busy;
   assign m_err   = sel ? bus_b.err   : bus_a.err;
   assign m_rdata = sel ? bus_b.rdata : bus_a.rdata;

   dm_responder #(.DEPTH(DEPTH), .WAIT(WAIT_A), .CW(4)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   dm_responder #(.DEPTH(DEPTH), .WAIT(WAIT_B), .CW(4)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_bad(input logic [31:0] a);
      return (a[31:2] >= 30'(DEPTH)) || (a[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      bit [32:0] key;
      key = {sel, a};
      return model.exists(key) ? model[key] : 32'h0;
   endfunction

   function automatic void model_wr(input logic [31:0] a, input logic [3:0] b,
                                    input logic [31:0] d);
      logic [31:0] w;
      w = model_rd(a);
      for (int l = 0; l < 4; l++) begin
         if (b[l]) w[8*l +: 8] = d[8*l +: 8];
      end
      model[{sel, a}] = w;
   endfunction

   // Builds the expected response for a request and updates the model.
   function automatic exp_t predict(input bit w, input logic [31:0] a, input logic [3:0] b,
                                    input logic [31:0] d);
      exp_t e;
      e.err       = is_bad(a);
      e.chk_rdata = !w || e.err;
      e.rdata     = (e.err || w) ? 32'h0 : model_rd(a);
      if (w && !e.err) model_wr(a, b, d);
      return e;
   endfunction

   // One complete transaction with latency, busy-length and single-pulse checks.
   task automatic txn(input bit w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d);
      int n;
      int nb;
      int unsigned wt;
      wt = sel ? WAIT_B : WAIT_A;
      sb.push_back(predict(w, a, b, d));
      @(negedge clk);
      req_s = 1'b1; we_s = w; addr_s = a; be_s = b; wdata_s = d;
      n = 0;
      nb = 0;
      do begin
         @(negedge clk);
         n++;
         if (m_busy) nb++;
      end while (!m_ack && n < 20);
      req_s = 1'b0;
      check("latency", 32'(n), 32'(wt + 1));
      check("busy_cycles", 32'(nb), 32'(wt + 1));
      @(negedge clk);
      check("ack_one_cycle", {31'h0, m_ack}, 32'h0);
      check("busy_idle", {31'h0, m_busy}, 32'h0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (reset && m_ack) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", {31'h0, m_ack}, 32'h0);
         end else begin
            mon_e = sb.pop_front();
            check("err", {31'h0, m_err}, {31'h0, mon_e.err});
            if (mon_e.chk_rdata) check("rdata", m_rdata, mon_e.rdata);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] v;
      sel = 1'b0; req_s = 1'b0; we_s = 1'b0; addr_s = '0; be_s = '0; wdata_s = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      check("rst_ack", {31'h0, bus_a.ack}, 32'h0);
      check("rst_busy", {31'h0, bus_a.busy}, 32'h0);
      check("rst_err", {31'h0, bus_a.err}, 32'h0);
      check("rst_rdata", bus_a.rdata, 32'h0);
      @(negedge clk) reset = 1'b1;

      // Basic load, full and partial stores
      txn(1'b0, 32'h0000_0000, 4'h0, 32'h0);
      txn(1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678);
      txn(1'b0, 32'h0000_0010, 4'h0, 32'h0);
      txn(1'b1, 32'h0000_0010, 4'b0010, 32'hAAAA_AAAA);
      txn(1'b0, 32'h0000_0010, 4'h0, 32'h0);
      txn(1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF);
      txn(1'b0, 32'h0000_0010, 4'h0, 32'h0);

      // Rejected accesses and the top boundary
      txn(1'b0, 32'h0000_3000, 4'h0, 32'h0);
      txn(1'b1, 32'h0000_0002, 4'b1111, 32'h1111_1111);
      txn(1'b0, 32'h0000_0000, 4'h0, 32'h0);
      txn(1'b1, 32'h0000_2FFC, 4'b1111, 32'h600D_F00D);
      txn(1'b0, 32'h0000_2FFC, 4'h0, 32'h0);
      txn(1'b0, 32'h0000_2FFD, 4'h0, 32'h0);

      // req held through ack; bus changes during WAIT must be ignored
      sb.push_back(predict(1'b1, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D));
      sb.push_back(predict(1'b0, 32'h0000_0010, 4'h0, 32'h0));
      @(negedge clk);
      req_s = 1'b1; we_s = 1'b1; addr_s = 32'h10; be_s = 4'b1111; wdata_s = 32'hCAFE_F00D;
      @(negedge clk);
      addr_s = 32'h14; wdata_s = 32'hDEAD_BEEF; be_s = 4'b0000;
      n = 0;
      while (!m_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      we_s = 1'b0; addr_s = 32'h10;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_ack && n < 20);
      req_s = 1'b0;
      check("b2b_gap", 32'(n), 32'(WAIT_A + 2));
      txn(1'b0, 32'h0000_0014, 4'h0, 32'h0);
      txn(1'b0, 32'h0000_0010, 4'h0, 32'h0);
      check("sb_drained", 32'(sb.size()), 32'h0);

      // Asynchronous reset in the middle of a store's wait states
      @(negedge clk);
      req_s = 1'b1; we_s = 1'b1; addr_s = 32'h20; be_s = 4'b1111; wdata_s = 32'h55AA_55AA;
      @(posedge clk);
      #1 check("mid_busy", {31'h0, bus_a.busy}, 32'h1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_ack", {31'h0, bus_a.ack}, 32'h0);
      check("mid_rst_busy", {31'h0, bus_a.busy}, 32'h0);
      check("mid_rst_rdata", bus_a.rdata, 32'h0);
      req_s = 1'b0;
      model.delete();
      @(negedge clk);
      @(negedge clk) reset = 1'b1;
      txn(1'b0, 32'h0000_0020, 4'h0, 32'h0);
      txn(1'b0, 32'h0000_0010, 4'h0, 32'h0);

      // Zero wait states: alternating store/load at the last word
      @(negedge clk) sel = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v = $urandom;
         txn(1'b1, 32'h0000_2FFC, 4'b1111, v);
         txn(1'b0, 32'h0000_2FFC, 4'h0, 32'h0);
      end
      txn(1'b0, 32'h0000_3000, 4'h0, 32'h0);

      @(negedge clk);
      @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
